// File: rtl/nibble_deserializer_if.sv
// Serial-side inputs and parallel-load outputs of the nibble deserializer.
// The master drives the serial line; the slave is the deserializer itself.
interface nibble_deserializer_if;
    logic       serial_in;
    logic       serial_valid;
    logic       abort;
    logic [3:0] d;
    logic       ld;
    logic       err;
    logic       busy;
    logic [7:0] frame_cnt;

    modport master (
        output serial_in, serial_valid, abort,
        input  d, ld, err, busy, frame_cnt
    );

    modport slave (
        input  serial_in, serial_valid, abort,
        output d, ld, err, busy, frame_cnt
    );
endinterface

// File: rtl/nibble_deserializer.sv
// Receives start + 4 data bits (LSB first) + parity, and presents each good nibble
// to a downstream parallel-load register with a one-cycle load strobe.
module nibble_deserializer #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    nibble_deserializer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_nx_s;
    logic [1:0] cnt_r;
    logic [1:0] cnt_nx_s;
    logic [3:0] shift_r;
    logic [3:0] shift_nx_s;

    logic [3:0] d_r;
    logic [3:0] d_nx_s;
    logic       ld_r;
    logic       ld_nx_s;
    logic       err_r;
    logic       err_nx_s;
    logic       busy_r;
    logic       busy_nx_s;
    logic [7:0] frame_cnt_r;
    logic [7:0] frame_cnt_nx_s;
    logic       par_ok_s;

    function automatic logic parity_ok(input logic [3:0] data, input logic par_bit);
        return (((^data) ^ par_bit) == PARITY_ODD);
    endfunction

    assign par_ok_s = parity_ok(shift_r, bus.serial_in);

    // State, counter, shift register and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            shift_r     <= 4'd0;
            d_r         <= 4'd0;
            ld_r        <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            shift_r     <= shift_nx_s;
            d_r         <= d_nx_s;
            ld_r        <= ld_nx_s;
            err_r       <= err_nx_s;
            busy_r      <= busy_nx_s;
            frame_cnt_r <= frame_cnt_nx_s;
        end
    end

    // Next-state, bit counter and shift register; abort overrides everything.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        shift_nx_s = shift_r;
        if (bus.abort) begin
            state_nx_s = IDLE;
            cnt_nx_s   = 2'd0;
            shift_nx_s = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.serial_valid && !bus.serial_in) begin
                        state_nx_s = DATA;
                        cnt_nx_s   = 2'd0;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                DATA: begin
                    if (bus.serial_valid) begin
                        // Shift in at the MSB so the first bit ends up in bit 0.
                        shift_nx_s = {bus.serial_in, shift_r[3:1]};
                        cnt_nx_s   = cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            state_nx_s = PARITY;
                        end else begin
                            state_nx_s = DATA;
                        end
                    end else begin
                        state_nx_s = DATA;
                    end
                end
                PARITY: begin
                    if (bus.serial_valid) begin
                        if (par_ok_s) begin
                            state_nx_s = DONE;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else begin
                        state_nx_s = PARITY;
                    end
                end
                DONE: begin
                    state_nx_s = IDLE;
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = 2'd0;
                    shift_nx_s = 4'd0;
                end
            endcase
        end
    end

    // Output updates produced by the parity-bit edge; abort suppresses them.
    always_comb begin
        d_nx_s         = d_r;
        ld_nx_s        = 1'b0;
        err_nx_s       = 1'b0;
        frame_cnt_nx_s = frame_cnt_r;
        busy_nx_s      = (state_nx_s != IDLE);
        if (!bus.abort && (state_r == PARITY) && bus.serial_valid) begin
            if (par_ok_s) begin
                d_nx_s         = shift_r;
                ld_nx_s        = 1'b1;
                frame_cnt_nx_s = frame_cnt_r + 8'd1;
            end else begin
                err_nx_s = 1'b1;
            end
        end else begin
            ld_nx_s  = 1'b0;
            err_nx_s = 1'b0;
        end
    end

    assign bus.d         = d_r;
    assign bus.ld        = ld_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;
    assign bus.frame_cnt = frame_cnt_r;

endmodule
